pipe_stall_ctrl: RTL and testbench
==================================

// Module: pipe_stall_ctrl
// PURPOSE
//  Pipeline stall/flush controller for the 5-stage core, one level above the ID-stage forwarding unit.
//  Covers the hazards forwarding cannot resolve: load-use, multi-cycle divide, data-memory wait and EX branch redirect.
//  Produces per-register stall/flush vectors for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
//  Has a small FSM plus bubble and watchdog counters.
// PARAMETERS
//  LOAD_USE_BUBBLES  1   bubbles inserted on a load-use hit (1..3)
//  DIV_TIMEOUT       40  max DIV_WAIT cycles before watchdog abort (>=2)
// PORTS
//  clk               in   1   core clock
//  rst               in   1   synchronous reset, active-high
//  id_reg1_raddr_i   in   5   ID rs1 address
//  id_reg2_raddr_i   in   5   ID rs2 address
//  id_reg1_RE_i      in   1   ID reads rs1
//  id_reg2_RE_i      in   1   ID reads rs2
//  ex_reg_waddr_i    in   5   EX rd
//  ex_reg_we_i       in   1   EX writes rd
//  ex_mem_re_i       in   1   EX instruction is a load
//  ex_div_start_i    in   1   1-cycle pulse: divide issued from EX
//  div_done_i        in   1   1-cycle pulse: divider result valid
//  ex_redirect_i     in   1   EX taken branch/jump; PC loads target when not stalled
//  mem_busy_i        in   1   data memory not ready for MEM-stage access
//  stall_o           out  5   hold register k: 0=PC 1=IF/ID 2=ID/EX 3=EX/MEM 4=MEM/WB
//  flush_o           out  5   load bubble into register k (same index; bit0 always 0)
//  div_timeout_o     out  1   1-cycle pulse: divide watchdog expired
// BEHAVIOUR
//  States: IDLE, LU_HOLD, DIV_WAIT. Registered: state, lu_cnt[1:0], div_cnt[5:0], div_timeout_o.
//  stall_o/flush_o are combinational from inputs and state; they act in the same cycle.
//  Reset (rst=1 at edge):
//   - state=IDLE, counters=0, div_timeout_o=0.
//   - While rst is high: stall_o=0, flush_o=5'b11110.
//  lu_hit = ex_mem_re_i & ex_reg_we_i & (ex_reg_waddr_i!=0) &
//           ((id_reg1_RE_i & rs1==ex rd) | (id_reg2_RE_i & rs2==ex rd)).
//  Priority, first match wins:
//   1. mem_busy_i: stall=5'b01111, flush=5'b10000. Redirect, lu_hit and new div starts are ignored.
//      Counters and state are frozen, except that div_done_i is still consumed.
//   2. DIV_WAIT and !div_done_i: stall=5'b00111, flush=5'b01000.
//   3. ex_redirect_i: stall=0, flush=5'b00110. If in LU_HOLD, go to IDLE and clear lu_cnt.
//   4. lu_hit, or LU_HOLD: stall=5'b00011, flush=5'b00100.
//   5. otherwise: stall=0, flush=0.
//  Transitions:
//   - IDLE->LU_HOLD: lu_hit, LOAD_USE_BUBBLES>1, and no higher-priority case. Load lu_cnt=LOAD_USE_BUBBLES-1.
//   - LU_HOLD: lu_cnt decrements each unstalled cycle; ->IDLE when lu_cnt==1 at the edge.
//   - With LOAD_USE_BUBBLES=1 the hit is served combinationally in one cycle and the FSM stays IDLE.
//   - IDLE->DIV_WAIT: ex_div_start_i (with no mem_busy_i). div_cnt=0.
//   - DIV_WAIT->IDLE: div_done_i. The same cycle releases the stall (case 2 not applied).
//   - DIV_WAIT: div_cnt++ per cycle. When div_cnt==DIV_TIMEOUT-1: ->IDLE, div_timeout_o=1 next cycle.
//  Simultaneous events:
//   - div_done_i and ex_div_start_i together: go to IDLE; the start is illegal and ignored.
//   - ex_div_start_i and lu_hit together: divide wins, state DIV_WAIT.
//  Reset mid-operation: from any state, the next edge yields IDLE with counters 0 and no timeout pulse.
// STRUCTURE
//  Shared package core_defines holds:
//   - STG_PC/STG_IFID/STG_IDEX/STG_EXMEM/STG_MEMWB index constants (0..4).
//   - State encodings: IDLE=2'd0, LU_HOLD=2'd1, DIV_WAIT=2'd2.
//  Sub-module load_use_detect: purely combinational lu_hit comparator.
//  The FSM, counters and output mux stay in this module.
// TESTING
//  - ex load rd=5, ID rs1=5 RE=1 -> same cycle stall=00011, flush=00100; next cycle 0 (BUBBLES=1).
//  - BUBBLES=3, same hit -> stall=00011 for 3 cycles, then 0; same hit with rd=0 -> no stall.
//  - ex_div_start_i, div_done_i 10 cycles later -> stall=00111, flush=01000 for 10 cycles; done cycle 0.
//  - div start, no done, DIV_TIMEOUT=40 -> stall for 40 cycles; div_timeout_o=1 for 1 cycle; IDLE.
//  - mem_busy_i 3 cycles with ex_redirect_i=1 -> stall=01111, flush=10000 x3; then flush=00110 once.
//  - rst asserted while in DIV_WAIT -> next cycle IDLE, stall_o=0, div_timeout_o never pulses.

Source files
------------

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared pipeline definitions: stage indices for stall/flush vectors and
// the stall-controller state encoding.
package core_defines;

    localparam int STG_PC    = 0;
    localparam int STG_IFID  = 1;
    localparam int STG_IDEX  = 2;
    localparam int STG_EXMEM = 3;
    localparam int STG_MEMWB = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LU_HOLD  = 2'd1,
        DIV_WAIT = 2'd2
    } stall_state_e;

    function automatic logic [4:0] stg(input int idx);
        return 5'(1) << idx;
    endfunction

    // Hold/bubble patterns for each hazard class.
    localparam logic [4:0] HOLD_MEM  = stg(STG_PC) | stg(STG_IFID) | stg(STG_IDEX) | stg(STG_EXMEM);
    localparam logic [4:0] BUB_MEM   = stg(STG_MEMWB);
    localparam logic [4:0] HOLD_DIV  = stg(STG_PC) | stg(STG_IFID) | stg(STG_IDEX);
    localparam logic [4:0] BUB_DIV   = stg(STG_EXMEM);
    localparam logic [4:0] BUB_REDIR = stg(STG_IFID) | stg(STG_IDEX);
    localparam logic [4:0] HOLD_LU   = stg(STG_PC) | stg(STG_IFID);
    localparam logic [4:0] BUB_LU    = stg(STG_IDEX);
    localparam logic [4:0] BUB_RST   = stg(STG_IFID) | stg(STG_IDEX) | stg(STG_EXMEM) | stg(STG_MEMWB);

endpackage

// File: rtl/pipe_stall_ctrl_load_use_detect.sv
// Combinational load-use comparator: the load in EX writes a register that
// the instruction in ID is about to read.
module load_use_detect (
    input  logic [4:0] id_reg1_raddr_i,
    input  logic [4:0] id_reg2_raddr_i,
    input  logic       id_reg1_re_i,
    input  logic       id_reg2_re_i,
    input  logic [4:0] ex_reg_waddr_i,
    input  logic       ex_reg_we_i,
    input  logic       ex_mem_re_i,
    output logic       lu_hit_o
);

    logic rs1_match;
    logic rs2_match;

    always_comb begin
        rs1_match = id_reg1_re_i && (id_reg1_raddr_i == ex_reg_waddr_i);
        rs2_match = id_reg2_re_i && (id_reg2_raddr_i == ex_reg_waddr_i);
        // x0 is never a real dependency.
        lu_hit_o  = ex_mem_re_i && ex_reg_we_i && (ex_reg_waddr_i != 5'd0)
                    && (rs1_match || rs2_match);
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush controller for the 5-stage core: load-use, multi-cycle divide,
// data-memory wait and EX redirect, with a divide watchdog.
module pipe_stall_ctrl
    import core_defines::*;
#(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int DIV_TIMEOUT      = 40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_reg1_raddr_i,
    input  logic [4:0] id_reg2_raddr_i,
    input  logic       id_reg1_RE_i,
    input  logic       id_reg2_RE_i,
    input  logic [4:0] ex_reg_waddr_i,
    input  logic       ex_reg_we_i,
    input  logic       ex_mem_re_i,
    input  logic       ex_div_start_i,
    input  logic       div_done_i,
    input  logic       ex_redirect_i,
    input  logic       mem_busy_i,
    output logic [4:0] stall_o,
    output logic [4:0] flush_o,
    output logic       div_timeout_o
);

    localparam logic [1:0] LU_LOAD  = 2'(LOAD_USE_BUBBLES - 1);
    localparam logic [5:0] DIV_LAST = 6'(DIV_TIMEOUT - 1);
    localparam bit         LU_MULTI = (LOAD_USE_BUBBLES > 1);

    stall_state_e state_q, state_d;
    logic [1:0]   lu_cnt_q, lu_cnt_d;
    logic [5:0]   div_cnt_q, div_cnt_d;
    logic         div_timeout_q, div_timeout_d;
    logic         lu_hit;

    load_use_detect u_lu_detect (
        .id_reg1_raddr_i (id_reg1_raddr_i),
        .id_reg2_raddr_i (id_reg2_raddr_i),
        .id_reg1_re_i    (id_reg1_RE_i),
        .id_reg2_re_i    (id_reg2_RE_i),
        .ex_reg_waddr_i  (ex_reg_waddr_i),
        .ex_reg_we_i     (ex_reg_we_i),
        .ex_mem_re_i     (ex_mem_re_i),
        .lu_hit_o        (lu_hit)
    );

    always_comb begin
        stall_o = '0;
        flush_o = '0;
        if (rst) begin
            flush_o = BUB_RST;
        end else if (mem_busy_i) begin
            stall_o = HOLD_MEM;
            flush_o = BUB_MEM;
        end else if ((state_q == DIV_WAIT) && !div_done_i) begin
            stall_o = HOLD_DIV;
            flush_o = BUB_DIV;
        end else if (ex_redirect_i) begin
            flush_o = BUB_REDIR;
        end else if (lu_hit || (state_q == LU_HOLD)) begin
            stall_o = HOLD_LU;
            flush_o = BUB_LU;
        end
    end

    always_comb begin
        state_d       = state_q;
        lu_cnt_d      = lu_cnt_q;
        div_cnt_d     = div_cnt_q;
        div_timeout_d = 1'b0;
        if (mem_busy_i) begin
            // Everything freezes, but a divider result must not be lost.
            if ((state_q == DIV_WAIT) && div_done_i) begin
                state_d   = IDLE;
                div_cnt_d = '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (ex_div_start_i) begin
                        state_d   = DIV_WAIT;
                        div_cnt_d = '0;
                    end else if (!ex_redirect_i && lu_hit && LU_MULTI) begin
                        state_d  = LU_HOLD;
                        lu_cnt_d = LU_LOAD;
                    end
                end
                LU_HOLD: begin
                    if (ex_redirect_i || (lu_cnt_q == 2'd1)) begin
                        state_d  = IDLE;
                        lu_cnt_d = '0;
                    end else begin
                        lu_cnt_d = lu_cnt_q - 2'd1;
                    end
                end
                DIV_WAIT: begin
                    if (div_done_i) begin
                        state_d   = IDLE;
                        div_cnt_d = '0;
                    end else if (div_cnt_q == DIV_LAST) begin
                        state_d       = IDLE;
                        div_cnt_d     = '0;
                        div_timeout_d = 1'b1;
                    end else begin
                        div_cnt_d = div_cnt_q + 6'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            lu_cnt_q      <= '0;
            div_cnt_q     <= '0;
            div_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            lu_cnt_q      <= lu_cnt_d;
            div_cnt_q     <= div_cnt_d;
            div_timeout_q <= div_timeout_d;
        end
    end

    assign div_timeout_o = div_timeout_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: one instance with 1 load-use bubble,
// one with 3, both driven by the same directed vectors.
module tb_pipe_stall_ctrl;

    localparam logic [4:0] Z     = 5'b00000;
    localparam logic [4:0] S_LU  = 5'b00011;
    localparam logic [4:0] F_LU  = 5'b00100;
    localparam logic [4:0] S_DIV = 5'b00111;
    localparam logic [4:0] F_DIV = 5'b01000;
    localparam logic [4:0] S_MEM = 5'b01111;
    localparam logic [4:0] F_MEM = 5'b10000;
    localparam logic [4:0] F_RD  = 5'b00110;
    localparam logic [4:0] F_RST = 5'b11110;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] rs1, rs2, ex_waddr;
    logic       re1, re2, ex_we, ex_mre, div_start, div_done, redirect, mem_busy;

    logic       s_rst;
    logic [4:0] s_rs1, s_rs2, s_ex_waddr;
    logic       s_re1, s_re2, s_ex_we, s_ex_mre, s_div_start, s_div_done, s_redirect, s_mem_busy;

    logic [4:0] stall1, flush1, stall3, flush3;
    logic       to1, to3;

    int          checks   = 0;
    int          failures = 0;
    logic [21:0] exp_q[$];
    string       name_q[$];
    logic [21:0] mon_exp, mon_act;
    string       mon_name;

    pipe_stall_ctrl #(.LOAD_USE_BUBBLES(1), .DIV_TIMEOUT(40)) dut1 (
        .clk(clk), .rst(rst),
        .id_reg1_raddr_i(rs1), .id_reg2_raddr_i(rs2),
        .id_reg1_RE_i(re1), .id_reg2_RE_i(re2),
        .ex_reg_waddr_i(ex_waddr), .ex_reg_we_i(ex_we), .ex_mem_re_i(ex_mre),
        .ex_div_start_i(div_start), .div_done_i(div_done),
        .ex_redirect_i(redirect), .mem_busy_i(mem_busy),
        .stall_o(stall1), .flush_o(flush1), .div_timeout_o(to1)
    );

    pipe_stall_ctrl #(.LOAD_USE_BUBBLES(3), .DIV_TIMEOUT(40)) dut3 (
        .clk(clk), .rst(rst),
        .id_reg1_raddr_i(rs1), .id_reg2_raddr_i(rs2),
        .id_reg1_RE_i(re1), .id_reg2_RE_i(re2),
        .ex_reg_waddr_i(ex_waddr), .ex_reg_we_i(ex_we), .ex_mem_re_i(ex_mre),
        .ex_div_start_i(div_start), .div_done_i(div_done),
        .ex_redirect_i(redirect), .mem_busy_i(mem_busy),
        .stall_o(stall3), .flush_o(flush3), .div_timeout_o(to3)
    );

    task automatic clr();
        s_rst = 1'b0; s_rs1 = '0; s_rs2 = '0; s_ex_waddr = '0;
        s_re1 = 1'b0; s_re2 = 1'b0; s_ex_we = 1'b0; s_ex_mre = 1'b0;
        s_div_start = 1'b0; s_div_done = 1'b0; s_redirect = 1'b0; s_mem_busy = 1'b0;
    endtask

    task automatic set_load(input logic [4:0] rd);
        s_ex_mre = 1'b1; s_ex_we = 1'b1; s_ex_waddr = rd;
    endtask

    // Apply staged inputs for the coming cycle and queue the expected outputs.
    task automatic step(input string nm, input logic [4:0] es, input logic [4:0] ef, input logic et,
                        input logic [4:0] es3, input logic [4:0] ef3, input logic et3);
        @(posedge clk);
        #1;
        rst = s_rst; rs1 = s_rs1; rs2 = s_rs2; ex_waddr = s_ex_waddr;
        re1 = s_re1; re2 = s_re2; ex_we = s_ex_we; ex_mre = s_ex_mre;
        div_start = s_div_start; div_done = s_div_done; redirect = s_redirect; mem_busy = s_mem_busy;
        exp_q.push_back({es, ef, es3, ef3, et, et3});
        name_q.push_back(nm);
    endtask

    task automatic same(input string nm, input logic [4:0] es, input logic [4:0] ef, input logic et);
        step(nm, es, ef, et, es, ef, et);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                mon_act  = {stall1, flush1, stall3, flush3, to1, to3};
                checks++;
                if (mon_act !== mon_exp) begin
                    failures++;
                    $display("FAIL %s @%0t: got stall1=%b flush1=%b to1=%b stall3=%b flush3=%b to3=%b, expected stall1=%b flush1=%b to1=%b stall3=%b flush3=%b to3=%b",
                             mon_name, $time,
                             mon_act[21:17], mon_act[16:12], mon_act[1], mon_act[11:7], mon_act[6:2], mon_act[0],
                             mon_exp[21:17], mon_exp[16:12], mon_exp[1], mon_exp[11:7], mon_exp[6:2], mon_exp[0]);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; rs1 = '0; rs2 = '0; ex_waddr = '0;
        re1 = 1'b0; re2 = 1'b0; ex_we = 1'b0; ex_mre = 1'b0;
        div_start = 1'b0; div_done = 1'b0; redirect = 1'b0; mem_busy = 1'b0;

        clr(); s_rst = 1'b1;
        same("reset_a", Z, F_RST, 1'b0);
        same("reset_b", Z, F_RST, 1'b0);
        clr();
        same("idle", Z, Z, 1'b0);

        // Load-use on rs1: one bubble vs three bubbles.
        set_load(5'd5); s_rs1 = 5'd5; s_re1 = 1'b1;
        same("lu_hit_rs1", S_LU, F_LU, 1'b0);
        clr();
        step("lu_bubble2", Z, Z, 1'b0, S_LU, F_LU, 1'b0);
        step("lu_bubble3", Z, Z, 1'b0, S_LU, F_LU, 1'b0);
        same("lu_release", Z, Z, 1'b0);

        set_load(5'd0); s_rs1 = 5'd0; s_re1 = 1'b1;
        same("lu_rd_zero", Z, Z, 1'b0);
        clr(); set_load(5'd9); s_rs1 = 5'd9; s_rs2 = 5'd9;
        same("lu_no_read_en", Z, Z, 1'b0);

        // rs2 hit, then a redirect cancels the remaining hold.
        clr(); set_load(5'd7); s_rs2 = 5'd7; s_re2 = 1'b1;
        same("lu_hit_rs2", S_LU, F_LU, 1'b0);
        clr(); s_redirect = 1'b1;
        same("redirect_in_hold", Z, F_RD, 1'b0);
        clr();
        same("after_redirect", Z, Z, 1'b0);

        set_load(5'd3); s_rs1 = 5'd3; s_re1 = 1'b1; s_redirect = 1'b1;
        same("redirect_beats_lu", Z, F_RD, 1'b0);
        clr();
        same("no_hold_after_redir", Z, Z, 1'b0);

        // Divide completing after 10 stalled cycles.
        s_div_start = 1'b1;
        same("div_start", Z, Z, 1'b0);
        clr();
        for (int i = 0; i < 10; i++) same("div_wait", S_DIV, F_DIV, 1'b0);
        s_div_done = 1'b1;
        same("div_done", Z, Z, 1'b0);
        clr();
        same("div_idle", Z, Z, 1'b0);

        // Divide start together with a load-use hit: divide wins.
        s_div_start = 1'b1; set_load(5'd4); s_rs1 = 5'd4; s_re1 = 1'b1;
        same("div_vs_lu", S_LU, F_LU, 1'b0);
        clr();
        same("div_won", S_DIV, F_DIV, 1'b0);
        s_div_done = 1'b1;
        same("div_won_done", Z, Z, 1'b0);

        // div_done arriving under mem_busy is still consumed.
        clr(); s_div_start = 1'b1;
        same("div_start2", Z, Z, 1'b0);
        clr();
        same("div_wait2", S_DIV, F_DIV, 1'b0);
        same("div_wait2", S_DIV, F_DIV, 1'b0);
        s_mem_busy = 1'b1; s_div_done = 1'b1;
        same("busy_with_done", S_MEM, F_MEM, 1'b0);
        clr();
        same("done_consumed", Z, Z, 1'b0);

        // Watchdog: 40 stalled cycles then a one-cycle timeout pulse.
        s_div_start = 1'b1;
        same("to_start", Z, Z, 1'b0);
        clr();
        for (int i = 0; i < 40; i++) same("to_wait", S_DIV, F_DIV, 1'b0);
        same("to_pulse", Z, Z, 1'b1);
        same("to_clear", Z, Z, 1'b0);

        // mem_busy masks a redirect, which then acts once busy drops.
        s_mem_busy = 1'b1; s_redirect = 1'b1;
        for (int i = 0; i < 3; i++) same("busy_redirect", S_MEM, F_MEM, 1'b0);
        s_mem_busy = 1'b0;
        same("redirect_after_busy", Z, F_RD, 1'b0);
        clr();
        same("busy_idle", Z, Z, 1'b0);

        // Reset in the middle of a divide wait.
        s_div_start = 1'b1;
        same("rst_div_start", Z, Z, 1'b0);
        clr();
        for (int i = 0; i < 3; i++) same("rst_div_wait", S_DIV, F_DIV, 1'b0);
        s_rst = 1'b1;
        same("rst_mid_div", Z, F_RST, 1'b0);
        clr();
        for (int i = 0; i < 45; i++) same("post_rst_idle", Z, Z, 1'b0);

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
